// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg
//   Shared definitions for the memory copy/fill DMA: default memory geometry
//   (64 words of 16 bits, RAM64-class) and the controller state encoding.
package mem_dma_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// mem_copy_dma
//   Single-port memory DMA engine driving a RAM64-class memory directly.
//   Copy mode moves length words from src_addr to dst_addr, strictly forward,
//   one READ cycle followed by one WRITE cycle per word. Fill mode writes
//   fill_data to length words starting at dst_addr, one word per cycle.
//   Addresses wrap modulo 2^ADDR_W; length above 2^ADDR_W is clamped.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   start, mode             request pulse (sampled in IDLE), 0=copy 1=fill
//   src_addr, dst_addr      first source / destination word address
//   length                  word count (ADDR_W+1 bits)
//   fill_data               fill pattern
//   busy, done              activity flag, one-cycle completion pulse
//   mem_address, mem_in     registered memory address / write data
//   mem_load                registered write enable (commits on next edge)
//   mem_out                 combinational read data from the memory
module mem_copy_dma
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] win_q, win_d;
  logic              load_q, load_d;
  logic [ADDR_W:0]   len_clamped_s;

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so that they are registered alongside the state.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d   = count_q;
    data_d    = data_q;
    fill_d    = fill_q;
    mode_d    = mode_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    win_d     = win_q;
    load_d    = 1'b0;

    if (length > MAX_LEN) begin
      len_clamped_s = MAX_LEN;
    end else begin
      len_clamped_s = length;
    end

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          count_d   = len_clamped_s;
          mode_d    = mode;
          fill_d    = fill_data;
          busy_d    = 1'b1;
          if (len_clamped_s == {(ADDR_W+1){1'b0}}) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (!mode) begin
            state_d = ST_READ;
            addr_d  = src_addr;
          end else begin
            state_d = ST_WRITE;
            addr_d  = dst_addr;
            win_d   = fill_data;
            load_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        // mem_out reflects the registered src address during this cycle.
        data_d  = mem_out;
        state_d = ST_WRITE;
        addr_d  = dst_ptr_q;
        win_d   = mem_out;
        load_d  = 1'b1;
      end

      ST_WRITE: begin
        src_ptr_d = src_ptr_q + ONE_ADDR;
        dst_ptr_d = dst_ptr_q + ONE_ADDR;
        count_d   = count_q - ONE_LEN;
        if (count_q == ONE_LEN) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (!mode_q) begin
          state_d = ST_READ;
          addr_d  = src_ptr_q + ONE_ADDR;
          win_d   = data_q;
        end else begin
          state_d = ST_WRITE;
          addr_d  = dst_ptr_q + ONE_ADDR;
          win_d   = fill_q;
          load_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts immediately with load low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      src_ptr_q <= {ADDR_W{1'b0}};
      dst_ptr_q <= {ADDR_W{1'b0}};
      count_q   <= {(ADDR_W+1){1'b0}};
      data_q    <= {DATA_W{1'b0}};
      fill_q    <= {DATA_W{1'b0}};
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      win_q     <= {DATA_W{1'b0}};
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
      fill_q    <= fill_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      win_q     <= win_d;
      load_q    <= load_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_address = addr_q;
  assign mem_in      = win_q;
  assign mem_load    = load_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma
//   Scoreboard bench for mem_copy_dma attached to a behavioural 64-word RAM.
//   Each command is expanded by a word-level reference model into the list of
//   (address, data) writes it must produce; a monitor pops that list on every
//   observed write. Completion latency, busy/done behaviour and the full RAM
//   image are also checked per command.
module tb_mem_copy_dma;
  import mem_dma_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [AW:0]   length;
  logic [DW-1:0] fill_data;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in;
  logic          mem_load;
  logic [DW-1:0] mem_out;

  int tests     = 0;
  int fails     = 0;
  int cycle_cnt = 0;
  int wr_cnt    = 0;

  logic [DW-1:0]    ram   [DEPTH];
  logic [DW-1:0]    model [DEPTH];
  logic [AW+DW-1:0] exp_q [$];

  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always #5 clk = ~clk;

  mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .fill_data  (fill_data),
    .busy       (busy),
    .done       (done),
    .mem_address(mem_address),
    .mem_in     (mem_in),
    .mem_load   (mem_load),
    .mem_out    (mem_out)
  );

  // RAM64 model: synchronous write, combinational read, bench preload port.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_load === 1'b1) ram[mem_address] <= mem_in;
  end
  assign mem_out = ram[mem_address];

  // Edge counter used for latency measurement.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Pops one expected write for every write the DUT presents.
  task automatic monitor();
    logic [AW+DW-1:0] item;
    forever begin
      @(negedge clk);
      if (mem_load === 1'b1) begin
        wr_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: addr %0d data 0x%0h with no write expected",
                   mem_address, mem_in);
        end else begin
          item = exp_q.pop_front();
          tests--;
          check("write_addr", 64'(mem_address), 64'(item[AW+DW-1:DW]));
          check("write_data", 64'(mem_in), 64'(item[DW-1:0]));
        end
      end
    end
  endtask

  task automatic preload_word(input int a, input logic [DW-1:0] v);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_addr = AW'(a);
    pre_data = v;
    model[AW'(a)] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_image(input string name);
    int mism;
    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== model[i]) mism++;
    end
    check(name, 64'(mism), 64'(0));
  endtask

  task automatic drive_cmd(input logic m, input int src, input int dst, input int len,
                           input logic [DW-1:0] fill);
    mode      = m;
    src_addr  = AW'(src);
    dst_addr  = AW'(dst);
    length    = (AW+1)'(len);
    fill_data = fill;
    start     = 1'b1;
  endtask

  // Issues one command, optionally with a second start while it is busy.
  task automatic run_cmd(input logic m, input int src, input int dst, input int len,
                         input logic [DW-1:0] fill, input bit poke);
    int            n, k, lat, seen, base;
    bit            busy_bad;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    n = (len > DEPTH) ? DEPTH : len;
    for (int j = 0; j < n; j++) begin
      a = AW'(dst + j);
      d = m ? fill : model[AW'(src + j)];
      model[a] = d;
      exp_q.push_back({a, d});
    end
    lat  = (n == 0) ? 0 : (m ? n : 2 * n);
    base = wr_cnt;
    @(negedge clk);
    drive_cmd(m, src, dst, len, fill);
    @(posedge clk);
    #1;
    k        = cycle_cnt;
    seen     = -1;
    busy_bad = 1'b0;
    for (int c = 0; c < 300 && seen < 0; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (poke && c == 3) drive_cmd(1'b1, 0, 50, 5, 16'hDEAD);
      if (poke && c == 4) start = 1'b0;
      if (done === 1'b1) seen = cycle_cnt - k;
      else if (busy !== 1'b1) busy_bad = 1'b1;
    end
    start = 1'b0;
    check("done_latency", 64'(seen), 64'(lat));
    if (n > 0) check("busy_during_op", 64'(busy_bad), 64'(0));
    @(negedge clk);
    #1;
    check("done_single_cycle", 64'(done), 64'(0));
    check("busy_clear_after_done", 64'(busy), 64'(0));
    check("write_count", 64'(wr_cnt - base), 64'(n));
    check("pending_writes", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    check_image("ram_image");
  endtask

  // Copy aborted by reset once three words have been written.
  task automatic run_abort();
    int            base;
    logic [AW-1:0] a;
    for (int j = 0; j < 3; j++) begin
      a = AW'(45 + j);
      model[a] = model[AW'(5 + j)];
      exp_q.push_back({a, model[a]});
    end
    base = wr_cnt;
    @(negedge clk);
    drive_cmd(1'b0, 5, 45, 8, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100 && wr_cnt < base + 3; c++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_mem_load", 64'(mem_load), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_mem_address", 64'(mem_address), 64'(0));
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("abort_write_count", 64'(wr_cnt - base), 64'(3));
    check("abort_pending", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    check_image("abort_ram_image");
  endtask

  initial begin
    fork
      monitor();
    join_none
    reset_n   = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    length    = '0;
    fill_data = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_mem_load", 64'(mem_load), 64'(0));
    check("reset_mem_address", 64'(mem_address), 64'(0));
    check("reset_mem_in", 64'(mem_in), 64'(0));
    reset_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) preload_word(i, DW'(16'h0100 + i));
    run_cmd(1'b0, 0, 32, 8, 16'h0000, 1'b0);     // copy 0..7 -> 32..39
    run_cmd(1'b1, 0, 62, 4, 16'hBEEF, 1'b0);     // fill wraps 62,63,0,1
    run_cmd(1'b0, 3, 9, 0, 16'h0000, 1'b0);      // zero length
    run_cmd(1'b1, 0, 17, 100, 16'h5A5A, 1'b0);   // clamps to 64 words

    for (int i = 0; i < DEPTH; i++) preload_word(i, DW'($urandom_range(0, 65535)));
    preload_word(10, 16'hAAAA);
    run_cmd(1'b0, 10, 11, 4, 16'h0000, 1'b0);    // forward overlap smear
    run_cmd(1'b0, 0, 20, 8, 16'h0000, 1'b1);     // second start ignored

    for (int r = 0; r < 12; r++) begin
      run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), int'($urandom_range(0, 80)),
              DW'($urandom_range(0, 65535)), 1'b0);
    end

    run_abort();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width of the attached RAM64-class memory.
REQ-002 Parameter DATA_W, default 16, memory word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low; one clock; reset is synchronous and active-low.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 mode  input  1  0 = copy (src to dst), 1 = fill (fill_data to dst).
REQ-007 src_addr  input  ADDR_W  first source word address (copy only).
REQ-008 dst_addr  input  ADDR_W  first destination word address.
REQ-009 length  input  ADDR_W+1  word count, 0..64; values above 64 clamp to 64.
REQ-010 fill_data  input  DATA_W  fill pattern (fill only).
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 mem_address  output  ADDR_W  memory address, registered.
REQ-014 mem_in  output  DATA_W  memory write data, registered.
REQ-015 mem_load  output  1  memory write enable, registered; the write commits on the next clk edge.
REQ-016 mem_out  input  DATA_W  memory read data, combinational from mem_address.

Function
REQ-017 The block SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-018 IDLE with start=1 SHALL latch src, dst, clamped length, mode and fill_data into internal registers, then transition as follows: length=0 to DONE; mode=0 to READ; mode=1 to WRITE.
REQ-019 READ SHALL drive mem_address=src_ptr and mem_load=0, capture mem_out into data_reg at the end of the cycle, and then go to WRITE.
REQ-020 WRITE SHALL drive mem_address=dst_ptr, mem_in=data_reg (copy) or fill_data latch (fill), and mem_load=1.
REQ-021 At the end of each WRITE cycle the block SHALL increment src_ptr and dst_ptr modulo 2^ADDR_W (63 wraps to 0) and decrement the count.
REQ-022 After a WRITE with count=1 the block SHALL go to DONE; otherwise it SHALL go to READ (copy) or stay in WRITE (fill).
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 Latency SHALL be start at edge k, done high in cycle k+2N+1 (copy), k+N+1 (fill) or k+1 (length 0).
REQ-025 mem_load SHALL be 0 in every state except WRITE, and exactly N writes SHALL occur per operation.
REQ-026 A start received while busy SHALL be ignored, with no queuing.
REQ-027 Copies SHALL run strictly forward, word by word, with no overlap correction; for example, with dst=src+1, src[0] propagates through the range.

Reset
REQ-028 reset_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, mem_load=0, mem_address=0, mem_in=0, pointers=0, count=0 and data_reg=0.
REQ-029 Reset asserted mid-operation SHALL abort within that edge with no further write; words already written remain.

Structure
REQ-030 The FSM state encoding and the ADDR_W/DATA_W defaults SHALL reside in a shared package, mem_dma_pkg.
REQ-031 The block SHALL be a single module with no sub-module, and SHALL connect directly to a RAM64 instance (address/in/load/out).

Verification
REQ-032 Copy test: preload RAM[i]=i+0x100; start copy src=0, dst=32, length=8 -> RAM[32..39]=0x100..0x107, done exactly at cycle k+17, 8 mem_load pulses.
REQ-033 Fill wrap test: fill dst=62, length=4, fill_data=0xBEEF -> RAM[62], RAM[63], RAM[0] and RAM[1] each equal 0xBEEF, done at k+5.
REQ-034 Length 0 and clamp test: length=0 -> done at k+1, no writes; length=100 fill -> exactly 64 writes, all RAM equal to the pattern.
REQ-035 Overlap test: RAM[10]=0xAAAA; copy src=10, dst=11, length=4 -> RAM[10..14] all 0xAAAA.
REQ-036 Busy start and abort test: a second start during the copy is ignored (destination unchanged for the second command); reset_n=0 after the third write -> mem_load=0 next cycle, busy=0, exactly 3 words written.
